// File: rtl/mem_io_responder.sv
// mem_io_responder: target side of the CPU byte bus.
// Holds the byte-wide RAM, decodes the I/O window at cpu_a[17:16]==2'b11,
// and provides the UART RX/TX byte streams, a free-running cycle counter with
// a coherent multi-byte snapshot, and the sticky program-stop flag.
module mem_io_responder #(
   parameter int RAM_ADDR_W  = 17,
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        tx_overflow,
   output logic        program_halt
);

   localparam int PTR_W     = $clog2(TX_DEPTH);
   localparam int OCC_W     = PTR_W + 1;
   localparam int RAM_DEPTH = 1 << RAM_ADDR_W;

   localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(TX_DEPTH);
   localparam logic [OCC_W-1:0] OCC_NEAR   = OCC_W'(TX_DEPTH - FULL_MARGIN);
   localparam logic [OCC_W-1:0] OCC_ONE    = OCC_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   localparam logic [15:0] OFF_UART = 16'h0000;
   localparam logic [15:0] OFF_CNT0 = 16'h0004;
   localparam logic [15:0] OFF_CNT1 = 16'h0005;
   localparam logic [15:0] OFF_CNT2 = 16'h0006;
   localparam logic [15:0] OFF_CNT3 = 16'h0007;

   // ------------------------------------------------------------------
   // Address decode (a request is presented every cycle)
   // ------------------------------------------------------------------
   logic                  io_sel;
   logic [15:0]           io_off;
   logic [RAM_ADDR_W-1:0] ram_idx;
   logic                  ram_we;
   logic                  ram_rd;
   logic                  io_rd;
   logic                  io_wr;
   logic                  rd_uart;
   logic                  rd_cnt0;
   logic                  wr_uart;
   logic                  wr_halt;
   logic                  unused_addr_bits;

   assign io_sel  = (cpu_a[17:16] == 2'b11);
   assign io_off  = cpu_a[15:0];
   assign ram_idx = cpu_a[RAM_ADDR_W-1:0];

   // RAM writes are held off while reset is asserted so a reset pulse
   // cannot corrupt memory contents through a stale bus request.
   assign ram_we  = ~io_sel & cpu_wr & ~rst_in;
   assign ram_rd  = ~io_sel & ~cpu_wr;
   assign io_rd   = io_sel & ~cpu_wr;
   assign io_wr   = io_sel & cpu_wr;

   assign rd_uart = io_rd & (io_off == OFF_UART);
   assign rd_cnt0 = io_rd & (io_off == OFF_CNT0);

   // A zero byte on the UART data register is not a character, so it is
   // silently discarded; the halt register pushes an explicit 0x00 marker.
   assign wr_uart = io_wr & (io_off == OFF_UART) & (cpu_dout != 8'h00);
   assign wr_halt = io_wr & (io_off == OFF_CNT0);

   // Upper address bits are outside the decoded 18-bit space.
   assign unused_addr_bits = ^cpu_a[31:18];

   // ------------------------------------------------------------------
   // Main RAM: one write port, registered read (maps onto block RAM)
   // ------------------------------------------------------------------
   logic [7:0] ram_mem [RAM_DEPTH];
   logic [7:0] ram_rd_q;

   // Byte write on request and registered read of the addressed byte.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         ram_mem[ram_idx] <= cpu_dout;
      end
      ram_rd_q <= ram_mem[ram_idx];
   end

   // ------------------------------------------------------------------
   // Cycle counter, snapshot and sticky halt flag
   // ------------------------------------------------------------------
   logic [31:0] cnt_q;
   logic [31:8] snap_q;
   logic        halt_q;

   // Counter runs until halted; a read of the low byte freezes the upper
   // bytes into the snapshot so a following multi-byte read is coherent.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q  <= 32'd0;
         snap_q <= 24'd0;
         halt_q <= 1'b0;
      end else begin
         if (!halt_q) begin
            cnt_q <= cnt_q + 32'd1;
         end
         if (rd_cnt0) begin
            snap_q <= cnt_q[31:8];
         end
         if (wr_halt) begin
            halt_q <= 1'b1;
         end
      end
   end

   assign program_halt = halt_q;

   // ------------------------------------------------------------------
   // I/O read data and response register
   // ------------------------------------------------------------------
   logic [7:0] io_rdata_d;
   logic       resp_ram_q;
   logic [7:0] resp_io_q;

   // Select the I/O read byte for the current request.
   always_comb begin
      io_rdata_d = 8'h00;
      if (io_rd) begin
         case (io_off)
            OFF_UART: io_rdata_d = rx_valid ? rx_data : 8'h00;
            OFF_CNT0: io_rdata_d = cnt_q[7:0];
            OFF_CNT1: io_rdata_d = snap_q[15:8];
            OFF_CNT2: io_rdata_d = snap_q[23:16];
            OFF_CNT3: io_rdata_d = snap_q[31:24];
            default:  io_rdata_d = 8'h00;
         endcase
      end
   end

   // Register the response source; reset forces any in-flight read to 0.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         resp_ram_q <= 1'b0;
         resp_io_q  <= 8'h00;
      end else begin
         resp_ram_q <= ram_rd;
         resp_io_q  <= io_rdata_d;
      end
   end

   // The RAM output register carries no reset, so the reset-cleared source
   // flag steers the bus to the (cleared) I/O byte until a RAM read lands.
   assign cpu_din = resp_ram_q ? ram_rd_q : resp_io_q;

   // The RX pop strobe belongs to the request cycle itself.
   assign rx_pop = rd_uart & rx_valid & ~rst_in;

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [OCC_W-1:0] occ_q;
   logic             ovf_q;
   logic             push_req;
   logic [7:0]       push_data;
   logic             pop;
   logic             fifo_full;
   logic             push_ok;

   assign push_req  = wr_uart | wr_halt;
   assign push_data = wr_halt ? 8'h00 : cpu_dout;
   assign pop       = tx_valid & tx_ready;
   assign fifo_full = (occ_q == OCC_FULL);

   // A push into a full FIFO still fits when the head leaves in the same cycle.
   assign push_ok   = push_req & (~fifo_full | pop);

   // FIFO storage: written at the tail, no reset needed.
   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         tx_mem[wr_ptr_q] <= push_data;
      end
   end

   // Pointer, occupancy and sticky overflow bookkeeping.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   occ_q <= occ_q + OCC_ONE;
            2'b01:   occ_q <= occ_q - OCC_ONE;
            default: occ_q <= occ_q;
         endcase
         if (push_req && !push_ok) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign tx_data        = tx_mem[rd_ptr_q];
   assign tx_valid       = (occ_q != '0);
   assign io_buffer_full = (occ_q >= OCC_NEAR);
   assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed scenarios followed by random
// traffic, checked against a queue/array reference model through a
// scoreboard drained by an independent monitor.
module tb_mem_io_responder;

   localparam int TX_DEPTH    = 8;
   localparam int FULL_MARGIN = 2;
   localparam logic [31:0] A_UART = 32'h0003_0000;
   localparam logic [31:0] A_CNT  = 32'h0003_0004;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] cpu_a = 32'd0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_dout = 8'd0;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic        tx_overflow;
   logic        program_halt;

   mem_io_responder #(
      .RAM_ADDR_W (17),
      .TX_DEPTH   (TX_DEPTH),
      .FULL_MARGIN(FULL_MARGIN)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .cpu_a         (cpu_a),
      .cpu_wr        (cpu_wr),
      .cpu_dout      (cpu_dout),
      .cpu_din       (cpu_din),
      .io_buffer_full(io_buffer_full),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_pop        (rx_pop),
      .tx_overflow   (tx_overflow),
      .program_halt  (program_halt)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int   due;
      logic rxpop;
      logic valid;
      logic full;
      logic ovf;
      logic halt;
   } comb_t;

   typedef struct {
      int         due;
      logic       chk;
      logic [7:0] val;
   } din_t;

   comb_t      comb_q[$];
   din_t       din_q[$];
   logic [7:0] sb_tx[$];

   // reference model state
   logic [7:0]  m_ram [int];
   logic [7:0]  m_fifo[$];
   logic [31:0] m_cnt  = 32'd0;
   logic [31:0] m_snap = 32'd0;
   logic        m_halt = 1'b0;
   logic        m_ovf  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares whatever the DUT presents against scoreboard entries.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         while (comb_q.size() != 0 && comb_q[0].due <= cyc) begin
            comb_t e;
            e = comb_q.pop_front();
            check("rx_pop", rx_pop, e.rxpop);
            check("tx_valid", tx_valid, e.valid);
            check("io_buffer_full", io_buffer_full, e.full);
            check("tx_overflow", tx_overflow, e.ovf);
            check("program_halt", program_halt, e.halt);
         end
         if (tx_valid && tx_ready) begin
            if (sb_tx.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL tx_unexpected: got 0x%0h, expected no byte (cycle %0d)", tx_data, cyc);
            end else begin
               check("tx_data", tx_data, sb_tx.pop_front());
            end
         end
         while (din_q.size() != 0 && din_q[0].due <= cyc) begin
            din_t d;
            d = din_q.pop_front();
            if (d.chk) begin
               check("cpu_din", cpu_din, d.val);
            end
         end
      end
   end

   // Present one request for the current cycle, update the model, advance.
   // Entered and left at posedge+1.
   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic rdy, input logic rxv, input logic [7:0] rxd);
      comb_t       ce;
      din_t        de;
      logic        io;
      logic [15:0] off;
      int          idx;
      logic        push;
      logic [7:0]  pdata;
      logic        pop;
      logic        halt_now;
      cpu_a    = a;
      cpu_wr   = wr;
      cpu_dout = d;
      tx_ready = rdy;
      rx_valid = rxv;
      rx_data  = rxd;
      io  = (a[17:16] == 2'b11);
      off = a[15:0];
      ce.due   = cyc;
      ce.rxpop = 1'b0;
      ce.valid = (m_fifo.size() != 0);
      ce.full  = (m_fifo.size() >= TX_DEPTH - FULL_MARGIN);
      ce.ovf   = m_ovf;
      ce.halt  = m_halt;
      de.due = cyc + 1;
      de.chk = 1'b0;
      de.val = 8'h00;
      push = 1'b0;
      pdata = 8'h00;
      halt_now = 1'b0;
      if (!io) begin
         idx = int'(a[16:0]);
         if (wr) m_ram[idx] = d;
         else if (m_ram.exists(idx)) begin
            de.chk = 1'b1;
            de.val = m_ram[idx];
         end
      end else if (!wr) begin
         de.chk = 1'b1;
         case (off)
            16'h0000: begin
               de.val   = rxv ? rxd : 8'h00;
               ce.rxpop = rxv;
            end
            16'h0004: begin
               m_snap = m_cnt;
               de.val = m_cnt[7:0];
            end
            16'h0005: de.val = m_snap[15:8];
            16'h0006: de.val = m_snap[23:16];
            16'h0007: de.val = m_snap[31:24];
            default:  de.val = 8'h00;
         endcase
      end else begin
         if (off == 16'h0000 && d != 8'h00) begin
            push = 1'b1;
            pdata = d;
         end
         if (off == 16'h0004) begin
            push = 1'b1;
            pdata = 8'h00;
            halt_now = 1'b1;
         end
      end
      pop = (m_fifo.size() != 0) && rdy;
      if (push && m_fifo.size() == TX_DEPTH && !pop) m_ovf = 1'b1;
      else if (push) begin
         m_fifo.push_back(pdata);
         sb_tx.push_back(pdata);
      end
      if (pop) void'(m_fifo.pop_front());
      if (!m_halt) m_cnt = m_cnt + 32'd1;
      if (halt_now) m_halt = 1'b1;
      comb_q.push_back(ce);
      din_q.push_back(de);
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int k = 0; k < n; k++) drive(32'h0000_1234, 1'b0, 8'h00, rdy, 1'b0, 8'h00);
   endtask

   // Assert reset mid-cycle, check outputs at once, then release at posedge+1.
   task automatic apply_reset(input int hold);
      #1;
      cpu_a    = A_UART;
      cpu_wr   = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h99;
      rst_in   = 1'b1;
      #1;
      check("rst_cpu_din", cpu_din, 32'h0);
      check("rst_rx_pop", rx_pop, 32'h0);
      check("rst_tx_valid", tx_valid, 32'h0);
      check("rst_io_buffer_full", io_buffer_full, 32'h0);
      check("rst_tx_overflow", tx_overflow, 32'h0);
      check("rst_program_halt", program_halt, 32'h0);
      comb_q.delete();
      din_q.delete();
      sb_tx.delete();
      m_fifo.delete();
      m_cnt  = 32'd0;
      m_snap = 32'd0;
      m_halt = 1'b0;
      m_ovf  = 1'b0;
      repeat (hold) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
   endtask

   logic [16:0] pool [8] = '{17'h01234, 17'h1FFFF, 17'h00000, 17'h0ABCD,
                             17'h10000, 17'h1F00F, 17'h00FF0, 17'h12345};

   initial begin
      @(posedge clk_in);
      #1;
      apply_reset(3);

      // RAM write then read-back, including the top byte
      drive(32'h0001_2345, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
      drive(32'h0001_2345, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      drive(32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
      drive(32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      drive(32'h0001_2345, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

      // TX ordering, zero byte ignored
      drive(A_UART, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
      drive(A_UART, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      drive(A_UART, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
      idle(1, 1'b0);
      idle(4, 1'b1);

      // fill to 8, push+pop at full, then drop on full
      for (int i = 0; i < TX_DEPTH; i++) drive(A_UART, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 8'h00);
      drive(A_UART, 1'b1, 8'h20, 1'b1, 1'b0, 8'h00);
      idle(1, 1'b0);
      drive(A_UART, 1'b1, 8'h21, 1'b0, 1'b0, 8'h00);
      idle(1, 1'b0);
      idle(10, 1'b1);

      // RX read with and without data
      drive(A_UART, 1'b0, 8'h00, 1'b0, 1'b1, 8'h37);
      drive(A_UART, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55);
      idle(1, 1'b0);

      // counter snapshot after 300 cycles
      apply_reset(2);
      idle(300, 1'b0);
      for (int i = 4; i < 8; i++) drive(32'h0003_0000 | i, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(1, 1'b0);

      // halt: stop marker, frozen counter
      drive(A_UART, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
      drive(A_CNT, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
      idle(2, 1'b1);
      drive(A_CNT, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(3, 1'b0);
      drive(A_CNT, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      drive(32'h0003_0005, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

      // reset in the middle of TX traffic
      for (int i = 0; i < 3; i++) drive(A_UART, 1'b1, 8'h61 + 8'(i), 1'b0, 1'b0, 8'h00);
      apply_reset(2);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a;
         logic [31:0] hi;
         logic        wr;
         logic [7:0]  d;
         int          r;
         if (i == 1500) apply_reset(1);
         hi = $urandom() & 32'hFFFC_0000;
         r  = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: a = hi | {15'd0, pool[$urandom_range(0, 7)]};
            4:          a = hi | 32'h0002_0000 | {16'd0, pool[$urandom_range(0, 7)][15:0]};
            5, 6:       a = hi | A_UART;
            7:          a = hi | 32'h0003_0004 | 32'($urandom_range(0, 3));
            8:          a = hi | 32'h0003_0000 | 32'($urandom_range(8, 16'hFFFF));
            default:    a = hi | 32'($urandom_range(0, 17'h1FFFF));
         endcase
         wr = 1'($urandom_range(0, 1));
         if (a[17:16] == 2'b11 && a[15:0] == 16'h0004 && wr && $urandom_range(0, 19) != 0) wr = 1'b0;
         d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom());
         drive(a, wr, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom()));
      end

      idle(TX_DEPTH + 4, 1'b1);
      check("tx_drained", sb_tx.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target-side counterpart of the CPU byte bus (address, write strobe, byte in, byte out).
- Holds the 128 KB RAM and decodes the I/O window at mem_a[17:16]==2'b11.
- Provides the UART RX/TX byte streams, the cycle counter, the program-stop flag and io_buffer_full back to the CPU.
- Sits between the CPU top and the UART/host-interface logic in the FPGA top.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB).
- TX_DEPTH, 8, TX FIFO entries (power of 2, minimum 4).
- FULL_MARGIN, 2, io_buffer_full asserts when occupancy >= TX_DEPTH - FULL_MARGIN.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous reset, active-high
- cpu_a  in  32  CPU address; only [17:0] decoded
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  write data from CPU
- cpu_din  out  8  read data to CPU, valid the cycle after the request
- io_buffer_full  out  1  TX FIFO near-full indication to CPU
- tx_data  out  8  head of TX FIFO
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART consumes head when tx_valid & tx_ready
- rx_data  in  8  received byte from UART
- rx_valid  in  1  rx_data available
- rx_pop  out  1  one-cycle pop strobe to RX source
- tx_overflow  out  1  sticky: a TX push was dropped because the FIFO was full
- program_halt  out  1  sticky: CPU wrote 0x30004

Behaviour:
- Reset (async, rst_in=1) values:
  - cpu_din=0, rx_pop=0, tx_overflow=0, program_halt=0.
  - TX FIFO empty, so tx_valid=0 and io_buffer_full=0.
  - Cycle counter=0, snapshot=0.
  - RAM contents are not reset.
- Decode, applied every cycle; there is no idle encoding, and the CPU issues a request every cycle.
  - io = (cpu_a[17:16]==2'b11).
  - RAM index = cpu_a[RAM_ADDR_W-1:0].
- RAM write (io=0, cpu_wr=1): byte stored at the clock edge. The same-address read on the next cycle returns the new value.
- RAM read (io=0, cpu_wr=0): cpu_din = RAM[index] registered, so latency is exactly 1 cycle.
- I/O read 0x30000:
  - If rx_valid, cpu_din(next) = rx_data and rx_pop=1 for the request cycle only.
  - Otherwise cpu_din(next) = 0x00 and rx_pop=0.
- I/O read 0x30004..0x30007:
  - A read of 0x30004 captures counter into snapshot and returns counter[7:0].
  - 0x30005, 0x30006 and 0x30007 return snapshot[15:8], [23:16] and [31:24].
  - Multi-byte reads are therefore coherent.
- Other I/O read addresses return 0x00.
- I/O write 0x30000:
  - cpu_dout != 0 pushes into the TX FIFO.
  - cpu_dout == 0 is ignored.
- I/O write 0x30004:
  - Sets program_halt.
  - Pushes 0x00 into the TX FIFO (stop marker), regardless of cpu_dout.
- Other I/O write addresses have no effect.
- TX FIFO:
  - Circular buffer with ptr width log2(TX_DEPTH) and an occupancy counter of width log2(TX_DEPTH)+1.
  - Pop when tx_valid & tx_ready.
  - Simultaneous push and pop: both happen and occupancy is unchanged. If full, the push is accepted because the pop frees a slot.
  - Push when full with no pop: data dropped, tx_overflow set.
  - Pointers wrap modulo TX_DEPTH.
  - tx_data = mem[rd_ptr], combinational from the registered array.
- io_buffer_full: combinational from occupancy, (occ >= TX_DEPTH-FULL_MARGIN). The margin covers the CPU's in-flight writes.
- Cycle counter:
  - Increments every cycle from reset release and wraps at 2^32.
  - Freezes once program_halt=1. The halting cycle's own increment still occurs.
- program_halt and tx_overflow clear only on reset.
- Reset mid-operation: FIFO contents are discarded, and any read response in flight is forced to 0.

Test Plan:
- Write 0xA5 to 0x01234, then read 0x01234 on the next cycle -> cpu_din=0xA5 exactly one cycle after the read. Reading 0x1FFFF after writing 0x3C there -> 0x3C.
- Write 0x41 then 0x00 then 0x42 to 0x30000 with tx_ready=0 -> occupancy 2. Then tx_ready=1 -> tx_data 0x41 then 0x42, then tx_valid=0.
- With tx_ready=0, TX_DEPTH=8, FULL_MARGIN=2, write 9 nonzero bytes -> io_buffer_full rises after the 6th push, 9th push dropped, tx_overflow=1. With occupancy 8, push and pop in the same cycle -> occupancy stays 8, no overflow.
- rx_valid=1, rx_data=0x37, read 0x30000 -> rx_pop pulses 1 cycle, next cycle cpu_din=0x37. rx_valid=0 -> cpu_din=0x00, no pop.
- Run 300 cycles after reset, then read 0x30004..0x30007 on consecutive cycles -> the four bytes assemble to snapshot 300 (0x0000012C), byte order 0x2C, 0x01, 0x00, 0x00. Counter preloaded to 0xFFFFFFFF -> wraps to 0.
- Write 0x30004 -> program_halt=1, 0x00 appears on tx_data, counter frozen. Assert rst_in mid-transfer -> all outputs return to reset values immediately.
